// File: rtl/cache_rd_responder_pkg.sv
// Shared codes for the cache refill read responder: request types, AXI burst type, FSM states.
package cache_rd_responder_pkg;

   localparam int unsigned RD_TYPE_W = 3;
   localparam int unsigned AXI_SIZE_W = 3;
   localparam int unsigned AXI_LEN_W = 8;
   localparam int unsigned AXI_BURST_W = 2;

   localparam logic [RD_TYPE_W-1:0] RT_BYTE = 3'd0;
   localparam logic [RD_TYPE_W-1:0] RT_HALF = 3'd1;
   localparam logic [RD_TYPE_W-1:0] RT_WORD = 3'd2;
   localparam logic [RD_TYPE_W-1:0] RT_LINE = 3'd4;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_e;

   // AXI size code for a request type; unknown codes fall back to a full word.
   function automatic logic [AXI_SIZE_W-1:0] size_of(input logic [RD_TYPE_W-1:0] t);
      case (t)
         RT_BYTE: size_of = 3'd0;
         RT_HALF: size_of = 3'd1;
         default: size_of = 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/cache_rd_responder.sv
// Memory-side responder: one cache read request -> one AXI4 AR burst -> R beats streamed back as ret_* words.
module cache_rd_responder
   import cache_rd_responder_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter logic [3:0]  AXI_ID     = 4'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [2:0]        rd_type,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_rdy,
   output logic              ret_valid,
   output logic              ret_last,
   output logic [DATA_W-1:0] ret_data,
   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [3:0]        rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;
   localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
   localparam logic [AXI_LEN_W-1:0] LINE_LEN = AXI_LEN_W'(LINE_WORDS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [7:0]          arlen_q, arlen_d;
   logic [2:0]          arsize_q, arsize_d;
   logic                arvalid_q, arvalid_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                err_q, err_d;
   logic                last_beat;
   logic                in_r;
   logic                unused_rid;

   // rid carries no information for a single-outstanding responder.
   assign unused_rid = ^rid;

   // Current beat is the final one of the burst by internal count.
   assign last_beat = (AXI_LEN_W'(beat_cnt_q) == arlen_q);

   // Next-state and request-latch logic.
   always_comb begin
      state_d    = state_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      arvalid_d  = arvalid_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               if (rd_type == RT_LINE) begin
                  araddr_d = rd_addr & LINE_MASK;
                  arlen_d  = LINE_LEN;
               end else begin
                  araddr_d = rd_addr;
                  arlen_d  = 8'd0;
               end
               arsize_d  = size_of(rd_type);
               arvalid_d = 1'b1;
               state_d   = ST_AR;
            end
         end
         ST_AR: begin
            if (arready) begin
               arvalid_d  = 1'b0;
               beat_cnt_d = '0;
               state_d    = ST_R;
            end
         end
         ST_R: begin
            if (rvalid) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if ((rresp != 2'b00) || (rlast != last_beat)) begin
                  err_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and AR-channel registers; reset aborts any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         arvalid_q  <= 1'b0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
         arvalid_q  <= arvalid_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   // R-phase pass-through; the cache master never backpressures.
   assign in_r      = (state_q == ST_R) && !rst;
   assign rd_rdy    = (state_q == ST_IDLE) && !rst;
   assign rready    = in_r;
   assign ret_valid = in_r && rvalid;
   assign ret_last  = in_r && rvalid && last_beat;
   assign ret_data  = rdata;

   assign arid    = AXI_ID;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arsize  = arsize_q;
   assign arburst = AXI_BURST_INCR;
   assign arvalid = arvalid_q;
   assign err     = err_q;

endmodule

// File: tb/tb_cache_rd_responder.sv
// Directed bench for cache_rd_responder: line/word reads, AR stall, R gaps, mid-burst reset, error flag.
module tb_cache_rd_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        err;

   int n_pass = 0;
   int n_chk  = 0;

   cache_rd_responder #(
      .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .AXI_ID(4'd0)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Present a request and walk the AR phase; arready stays low for 'stall' cycles.
   task automatic do_req(input logic [2:0] t, input logic [31:0] a, input logic [31:0] exp_addr,
                         input logic [7:0] exp_len, input logic [2:0] exp_size, input int stall);
      @(negedge clk);
      rd_req = 1'b1; rd_type = t; rd_addr = a; arready = 1'b0;
      #1 chk("rd_rdy_idle", 64'(rd_rdy), 64'd1);
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      chk("arvalid_up", 64'(arvalid), 64'd1);
      chk("araddr", 64'(araddr), 64'(exp_addr));
      chk("arlen", 64'(arlen), 64'(exp_len));
      chk("arsize", 64'(arsize), 64'(exp_size));
      chk("arburst", 64'(arburst), 64'd1);
      chk("arid", 64'(arid), 64'd0);
      chk("rd_rdy_busy", 64'(rd_rdy), 64'd0);
      for (int i = 0; i < stall; i++) begin
         rvalid = 1'b1; rdata = 32'hDEAD_0000;
         @(negedge clk);
         #1;
         chk("stall_arvalid", 64'(arvalid), 64'd1);
         chk("stall_araddr", 64'(araddr), 64'(exp_addr));
         chk("stall_rd_rdy", 64'(rd_rdy), 64'd0);
         chk("stall_ret_valid", 64'(ret_valid), 64'd0);
      end
      rvalid = 1'b0;
      arready = 1'b1;
   endtask

   // One R-channel cycle with the expected ret_* view of it.
   task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic [1:0] resp,
                       input logic exp_last);
      @(negedge clk);
      arready = 1'b0;
      rvalid = v; rdata = d; rlast = l; rresp = resp;
      #1;
      chk("rready", 64'(rready), 64'd1);
      chk("arvalid_down", 64'(arvalid), 64'd0);
      chk("ret_valid", 64'(ret_valid), 64'(v));
      if (v) chk("ret_data", 64'(ret_data), 64'(d));
      chk("ret_last", 64'(ret_last), 64'(exp_last));
   endtask

   task automatic quiet();
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd_req = 1'b0; rd_type = 3'd0; rd_addr = '0; arready = 1'b0;
      rid = 4'hF; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      #1;
      chk("rst_rd_rdy", 64'(rd_rdy), 64'd0);
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_araddr", 64'(araddr), 64'd0);
      chk("rst_arlen", 64'(arlen), 64'd0);
      chk("rst_arsize", 64'(arsize), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rready", 64'(rready), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Line read, aligned down to the 16-byte line.
      do_req(3'd4, 32'h1C00_0014, 32'h1C00_0010, 8'd3, 3'd2, 0);
      beat(1'b1, 32'hA0, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hA1, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hA2, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hA3, 1'b1, 2'b00, 1'b1);
      quiet();
      #1;
      chk("line_rd_rdy_after", 64'(rd_rdy), 64'd1);
      chk("line_err", 64'(err), 64'd0);
      chk("line_ret_valid_idle", 64'(ret_valid), 64'd0);

      // Word read: single beat carries ret_valid and ret_last together.
      do_req(3'd2, 32'h8000_0004, 32'h8000_0004, 8'd0, 3'd2, 0);
      beat(1'b1, 32'h1234_5678, 1'b1, 2'b00, 1'b1);
      quiet();

      // Byte, half and an undefined code; each a single beat.
      do_req(3'd0, 32'h0000_0103, 32'h0000_0103, 8'd0, 3'd0, 0);
      beat(1'b1, 32'hB0, 1'b1, 2'b00, 1'b1);
      quiet();
      do_req(3'd1, 32'h0000_0202, 32'h0000_0202, 8'd0, 3'd1, 0);
      beat(1'b1, 32'hB1, 1'b1, 2'b00, 1'b1);
      quiet();
      do_req(3'd7, 32'h0000_0301, 32'h0000_0301, 8'd0, 3'd2, 0);
      beat(1'b1, 32'hB2, 1'b1, 2'b00, 1'b1);
      quiet();

      // AR stall: arready low for 5 cycles.
      do_req(3'd2, 32'h4000_0008, 32'h4000_0008, 8'd0, 3'd2, 5);
      beat(1'b1, 32'hC0, 1'b1, 2'b00, 1'b1);
      quiet();
      #1 chk("stall_err", 64'(err), 64'd0);

      // R gaps: rvalid pattern 1,0,0,1,1,0,1.
      do_req(3'd4, 32'h2000_003C, 32'h2000_0030, 8'd3, 3'd2, 0);
      beat(1'b1, 32'hD0, 1'b0, 2'b00, 1'b0);
      beat(1'b0, 32'hEE, 1'b0, 2'b00, 1'b0);
      beat(1'b0, 32'hEE, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hD1, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hD2, 1'b0, 2'b00, 1'b0);
      beat(1'b0, 32'hEE, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hD3, 1'b1, 2'b00, 1'b1);
      quiet();
      #1;
      chk("gap_rd_rdy_after", 64'(rd_rdy), 64'd1);
      chk("gap_err", 64'(err), 64'd0);

      // Reset after beat 2 of a line read, with rvalid still high.
      do_req(3'd4, 32'h3000_0000, 32'h3000_0000, 8'd3, 3'd2, 0);
      beat(1'b1, 32'hE0, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hE1, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hE2; rst = 1'b1;
      #1;
      chk("midrst_rready", 64'(rready), 64'd0);
      chk("midrst_ret_valid", 64'(ret_valid), 64'd0);
      chk("midrst_ret_last", 64'(ret_last), 64'd0);
      @(negedge clk);
      rst = 1'b0; rvalid = 1'b0;
      #1;
      chk("postrst_rd_rdy", 64'(rd_rdy), 64'd1);
      chk("postrst_arvalid", 64'(arvalid), 64'd0);
      chk("postrst_err", 64'(err), 64'd0);
      chk("postrst_rready", 64'(rready), 64'd0);

      // Early rlast on beat 2: err set, ret_last still follows the count.
      do_req(3'd4, 32'h5000_0010, 32'h5000_0010, 8'd3, 3'd2, 0);
      beat(1'b1, 32'hF0, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'hF1, 1'b1, 2'b00, 1'b0);
      beat(1'b1, 32'hF2, 1'b0, 2'b00, 1'b0);
      #1 chk("early_rlast_err", 64'(err), 64'd1);
      beat(1'b1, 32'hF3, 1'b0, 2'b00, 1'b1);
      quiet();
      #1 chk("early_rlast_rd_rdy", 64'(rd_rdy), 64'd1);
      pulse_rst();
      #1 chk("err_cleared", 64'(err), 64'd0);

      // rresp=SLVERR on beat 1: err sticky across a later clean read.
      do_req(3'd4, 32'h6000_0020, 32'h6000_0020, 8'd3, 3'd2, 0);
      beat(1'b1, 32'h10, 1'b0, 2'b10, 1'b0);
      beat(1'b1, 32'h11, 1'b0, 2'b00, 1'b0);
      #1 chk("rresp_err", 64'(err), 64'd1);
      beat(1'b1, 32'h12, 1'b0, 2'b00, 1'b0);
      beat(1'b1, 32'h13, 1'b1, 2'b00, 1'b1);
      quiet();
      do_req(3'd2, 32'h6000_0100, 32'h6000_0100, 8'd0, 3'd2, 0);
      beat(1'b1, 32'h14, 1'b1, 2'b00, 1'b1);
      quiet();
      #1 chk("err_sticky", 64'(err), 64'd1);
      pulse_rst();
      #1 chk("err_reset", 64'(err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
